// File: rtl/echo_tap_reader_pkg.sv
// Shared constants and types for the echo delay-line read path.
package echo_pkg;

    localparam int DEPTH          = 132300;
    localparam int ADDR_W         = 18;
    localparam int DATA_W         = 16;
    localparam int SAMPLES_PER_MS = 44;
    localparam int GAIN_W         = 8;
    localparam int DELAY_W        = 12;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_DRY  = 3'd1,
        RD_WET  = 3'd2,
        CAPTURE = 3'd3,
        MIX     = 3'd4,
        DONE    = 3'd5
    } state_t;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic        [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/echo_tap_reader_mixer.sv
// Registered wet-gain multiply, floor shift and dry+wet sum.
// ECHO_TAP_SAT_EN selects saturation of the sum; otherwise it wraps.
module echo_mixer
    import echo_pkg::*;
(
    input  logic              clkMain,
    input  logic              rst,
    input  logic              en,
    input  sample_t           dry,
    input  sample_t           wet,
    input  logic [GAIN_W-1:0] gain,
    output sample_t           out_sample,
    output logic              out_valid
);

    logic signed [DATA_W+GAIN_W:0] prod;
    logic signed [DATA_W:0]        wet_scaled;
    logic signed [DATA_W:0]        sum;
    sample_t                       mixed;
    logic                          unused_bits;

    // The product keeps its low GAIN_W bits only so the shift is an exact floor.
    always_comb begin
        prod       = wet * $signed({1'b0, gain});
        wet_scaled = prod[DATA_W+GAIN_W:GAIN_W];
        sum        = {dry[DATA_W-1], dry} + wet_scaled;
`ifdef ECHO_TAP_SAT_EN
        if (sum[DATA_W] != sum[DATA_W-1])
            mixed = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            mixed = sum[DATA_W-1:0];
        unused_bits = ^prod[GAIN_W-1:0];
`else
        mixed       = sum[DATA_W-1:0];
        unused_bits = ^{prod[GAIN_W-1:0], sum[DATA_W]};
`endif
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            out_sample <= '0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= en;
            if (en)
                out_sample <= mixed;
        end
    end

endmodule

// File: rtl/echo_tap_reader.sv
// Echo delay-line reader: fetches dry and delayed taps, mixes them with a wet gain.
// Build option ECHO_TAP_SAT_EN saturates the mix instead of wrapping.
module echo_tap_reader
    import echo_pkg::*;
(
    input  logic               clkMain,
    input  logic               rst,
    input  logic               sample_strobe,
    input  logic [ADDR_W-1:0]  wr_ptr,
    input  logic [DELAY_W-1:0] delay,
    input  logic [GAIN_W-1:0]  gain,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [DATA_W-1:0]  out_sample,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic [2:0]         dbg_state
);

    // Handshake: sample_strobe is a single-cycle request accepted only in IDLE
    // (busy=0); a strobe seen while busy is dropped and flagged on sticky overrun.
    // out_valid is a single-cycle pulse five cycles after an accepted strobe, and
    // out_sample holds its value until the next pulse. No backpressure exists.

    localparam addr_t DEPTH_A  = addr_t'(DEPTH);
    localparam addr_t DEPTH_M1 = addr_t'(DEPTH - 1);

    state_t             state;
    addr_t              wr_ptr_l;
    logic [DELAY_W-1:0] delay_l;
    logic [GAIN_W-1:0]  gain_l;
    sample_t            dry_r;
    sample_t            wet_r;
    addr_t              d_raw;
    addr_t              d_samp;
    addr_t              tap_addr;
    sample_t            mix_out;

    // Wrap branch adds (DEPTH - d_samp) first so the sum never exceeds ADDR_W bits.
    always_comb begin
        d_raw    = addr_t'(delay_l) * addr_t'(SAMPLES_PER_MS);
        d_samp   = (d_raw >= DEPTH_A) ? DEPTH_M1 : d_raw;
        tap_addr = (wr_ptr_l >= d_samp) ? (wr_ptr_l - d_samp)
                                        : (wr_ptr_l + (DEPTH_A - d_samp));
    end

    always_ff @(posedge clkMain) begin
        if (rst) begin
            state    <= IDLE;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
            wr_ptr_l <= '0;
            delay_l  <= '0;
            gain_l   <= '0;
            dry_r    <= '0;
            wet_r    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        wr_ptr_l <= wr_ptr;
                        delay_l  <= delay;
                        gain_l   <= gain;
                        rd_en    <= 1'b1;
                        rd_addr  <= wr_ptr;
                        busy     <= 1'b1;
                        state    <= RD_DRY;
                    end
                end
                RD_DRY: begin
                    rd_addr <= tap_addr;
                    state   <= RD_WET;
                end
                RD_WET: begin
                    dry_r <= rd_data;
                    rd_en <= 1'b0;
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    wet_r <= rd_data;
                    state <= MIX;
                end
                MIX: begin
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
            if (sample_strobe && state != IDLE)
                overrun <= 1'b1;
        end
    end

    echo_mixer u_mixer (
        .clkMain    (clkMain),
        .rst        (rst),
        .en         (state == MIX),
        .dry        (dry_r),
        .wet        (wet_r),
        .gain       (gain_l),
        .out_sample (mix_out),
        .out_valid  (out_valid)
    );

    assign out_sample = mix_out;
    assign dbg_state  = state;

endmodule

// File: tb/tb_echo_tap_reader.sv
// Directed bench for echo_tap_reader: vector table plus reset/overrun sequences.
module tb_echo_tap_reader;

    localparam int DEPTH = 132300;

    logic        clkMain;
    logic        rst;
    logic        sample_strobe;
    logic [17:0] wr_ptr;
    logic [11:0] delay;
    logic [7:0]  gain;
    logic        rd_en;
    logic [17:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic [2:0]  dbg_state;

    logic [15:0] ram [0:DEPTH-1];
    logic [15:0] exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [17:0] wr;
        logic [11:0] dl;
        logic [7:0]  gn;
        logic [15:0] dry;
        logic [15:0] wet;
        logic [17:0] tap;
        logic [15:0] exp_sat;
        logic [15:0] exp_wrap;
    } vec_t;

    vec_t vecs [7];

    echo_tap_reader dut (
        .clkMain       (clkMain),
        .rst           (rst),
        .sample_strobe (sample_strobe),
        .wr_ptr        (wr_ptr),
        .delay         (delay),
        .gain          (gain),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .out_sample    (out_sample),
        .out_valid     (out_valid),
        .busy          (busy),
        .overrun       (overrun),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clkMain = 1'b0;
    always #5 clkMain = ~clkMain;

    // registered-read RAM model
    always @(posedge clkMain) begin
        if (rd_en)
            rd_data <= ram[rd_addr];
    end

    always @(posedge clkMain) begin
        if (sample_strobe)
            assert (wr_ptr < DEPTH) else $error("illegal wr_ptr %0d", wr_ptr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every out_valid pulse pops one expected sample
    always @(negedge clkMain) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 sample 0x%0h, required no pulse", out_sample);
            end else begin
                check("out_sample", {16'd0, out_sample}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [15:0] exp_of(input vec_t v);
`ifdef ECHO_TAP_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    task automatic load_ram(input vec_t v);
        ram[v.wr] = v.dry;
        if (v.tap != v.wr)
            ram[v.tap] = v.wet;
    endtask

    task automatic drive(input vec_t v, input logic stb);
        wr_ptr        = v.wr;
        delay         = v.dl;
        gain          = v.gn;
        sample_strobe = stb;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clkMain);
        drive(v, 1'b1);
        exp_q.push_back(exp_of(v));
        @(negedge clkMain);                      // T+1
        sample_strobe = 1'b0;
        check("rd_en_t1", {31'd0, rd_en}, 32'd1);
        check("rd_addr_dry", {14'd0, rd_addr}, {14'd0, v.wr});
        check("busy_t1", {31'd0, busy}, 32'd1);
        @(negedge clkMain);                      // T+2
        check("rd_en_t2", {31'd0, rd_en}, 32'd1);
        check("rd_addr_tap", {14'd0, rd_addr}, {14'd0, v.tap});
        @(negedge clkMain);                      // T+3
        check("rd_en_t3", {31'd0, rd_en}, 32'd0);
        @(negedge clkMain);                      // T+4
        check("valid_t4", {31'd0, out_valid}, 32'd0);
        @(negedge clkMain);                      // T+5
        check("valid_t5", {31'd0, out_valid}, 32'd1);
        @(negedge clkMain);                      // T+6
        check("valid_t6", {31'd0, out_valid}, 32'd0);
        check("busy_t6", {31'd0, busy}, 32'd0);
        check("hold_sample", {16'd0, out_sample}, {16'd0, exp_of(v)});
    endtask

    initial begin
        vecs[0] = '{18'd100,    12'd0,    8'd128, 16'd1000,    16'd1000,    18'd100,    16'd1500,    16'd1500};
        vecs[1] = '{18'd10,     12'd1,    8'd128, 16'd200,     16'(-400),   18'd132266, 16'd0,       16'd0};
        vecs[2] = '{18'd5,      12'd4095, 8'd64,  16'(-100),   16'(-3),     18'd6,      16'(-101),   16'(-101)};
        vecs[3] = '{18'd50000,  12'd500,  8'd255, 16'd30000,   16'd30000,   18'd28000,  16'd32767,   16'(-5654)};
        vecs[4] = '{18'd1000,   12'd1000, 8'd255, 16'(-30000), 16'(-30000), 18'd89300,  16'h8000,    16'd5653};
        vecs[5] = '{18'd132299, 12'd3007, 8'd0,   16'd7,       16'd12345,   18'd0,      16'd7,       16'd7};
        vecs[6] = '{18'd0,      12'd3006, 8'd200, 16'(-5),     16'd256,     18'd36,     16'd195,     16'd195};

        rst = 1'b1;
        sample_strobe = 1'b0;
        wr_ptr = '0;
        delay = '0;
        gain = '0;
        repeat (3) @(negedge clkMain);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_rd_addr", {14'd0, rd_addr}, 32'd0);
        check("rst_out_sample", {16'd0, out_sample}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);

        // strobe while reset is held must not start a sequence
        for (int i = 0; i < 7; i++) load_ram(vecs[i]);
        drive(vecs[0], 1'b1);
        @(negedge clkMain);
        sample_strobe = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clkMain);
            check("rst_strobe_rd_en", {31'd0, rd_en}, 32'd0);
            check("rst_strobe_busy", {31'd0, busy}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clkMain);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // overrun: strobes at T and T+2, then a clean strobe at T+6
        check("overrun_pre", {31'd0, overrun}, 32'd0);
        @(negedge clkMain);
        drive(vecs[0], 1'b1);
        exp_q.push_back(exp_of(vecs[0]));
        @(negedge clkMain);                      // T+1
        sample_strobe = 1'b0;
        check("ovr_t1", {31'd0, overrun}, 32'd0);
        @(negedge clkMain);                      // T+2
        drive(vecs[1], 1'b1);
        check("ovr_t2", {31'd0, overrun}, 32'd0);
        @(negedge clkMain);                      // T+3
        sample_strobe = 1'b0;
        check("ovr_t3", {31'd0, overrun}, 32'd1);
        check("ovr_rd_en_t3", {31'd0, rd_en}, 32'd0);
        @(negedge clkMain);                      // T+4
        @(negedge clkMain);                      // T+5
        check("ovr_valid_t5", {31'd0, out_valid}, 32'd1);
        @(negedge clkMain);                      // T+6
        check("ovr_busy_t6", {31'd0, busy}, 32'd0);
        drive(vecs[1], 1'b1);
        exp_q.push_back(exp_of(vecs[1]));
        @(negedge clkMain);                      // T+7
        sample_strobe = 1'b0;
        check("t6_rd_en", {31'd0, rd_en}, 32'd1);
        check("t6_rd_addr", {14'd0, rd_addr}, {14'd0, vecs[1].wr});
        @(negedge clkMain);
        check("t6_rd_tap", {14'd0, rd_addr}, {14'd0, vecs[1].tap});
        repeat (4) @(negedge clkMain);
        check("ovr_sticky", {31'd0, overrun}, 32'd1);
        rst = 1'b1;
        @(negedge clkMain);
        rst = 1'b0;
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // reset in the middle of a sequence: no pulse may follow
        @(negedge clkMain);
        drive(vecs[3], 1'b1);
        @(negedge clkMain);
        sample_strobe = 1'b0;
        @(negedge clkMain);
        @(negedge clkMain);                      // T+3
        rst = 1'b1;
        @(negedge clkMain);
        rst = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rd_en", {31'd0, rd_en}, 32'd0);
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        repeat (5) @(negedge clkMain);
        check("abort_out_sample", {16'd0, out_sample}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/echo_tap_reader.md
Name: echo_tap_reader

Overview:
- Read side of the audio delay line: consumes the circular sample buffer that the delay-memory writer fills at sample rate.
- On each new-sample strobe, fetches the newest (dry) sample and the delayed (wet) tap from the buffer RAM, then scales the wet tap by a gain.
- Mixes dry and wet into one echo output sample with a one-cycle valid pulse.
- Sits between the delay-memory RAM read port and the output DAC/serializer path, entirely in the clkMain domain.

Parameters:
- DEPTH, 132300, buffer length in samples (3 s at 44.1 kHz)
- ADDR_W, 18, RAM address width (must satisfy 2^ADDR_W >= DEPTH)
- DATA_W, 16, signed sample width
- SAMPLES_PER_MS, 44, delay-in-ms to samples multiplier
- GAIN_W, 8, unsigned wet gain width; gain is in Q0.8, so 255 = 0.996

Ports:
- clkMain  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- sample_strobe  in  1  one-cycle pulse: writer has just stored a sample at wr_ptr
- wr_ptr  in  ADDR_W  address of most recent written sample, 0..DEPTH-1
- delay  in  12  echo delay in ms
- gain  in  GAIN_W  wet gain
- rd_en  out  1  RAM read enable
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en (registered read)
- out_sample  out  DATA_W  mixed signed sample
- out_valid  out  1  one-cycle pulse, out_sample new
- busy  out  1  high in any state except IDLE
- overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Reset values:
  - rd_en=0, rd_addr=0, out_sample=0, out_valid=0, busy=0, overrun=0.
  - FSM goes to IDLE.
- Reset mid-operation aborts the sequence; no out_valid is issued.
- Input latching: in IDLE, sample_strobe high at cycle T latches wr_ptr, delay and gain.
- FSM sequence, one state per cycle:
  - IDLE -> RD_DRY (T+1): rd_en=1, rd_addr=wr_ptr_l.
  - RD_WET (T+2): rd_en=1, rd_addr=tap_addr. The dry word is captured from rd_data.
  - CAPTURE (T+3): rd_en=0. The wet word is captured.
  - MIX (T+4): registers the product and the sum.
  - DONE (T+5): out_valid=1 for exactly one cycle, out_sample updated, then back to IDLE.
- Fixed latency: strobe to out_valid is 5 cycles. Next strobe is accepted at T+6 or later.
- Delay conversion:
  - d_samp = delay*SAMPLES_PER_MS, computed at a 18-bit minimum width.
  - If d_samp >= DEPTH, it is clamped to DEPTH-1.
  - delay=0 gives tap_addr=wr_ptr (wet equals dry).
- Wrap-around: tap_addr = wr_ptr_l - d_samp when wr_ptr_l >= d_samp, else wr_ptr_l + DEPTH - d_samp. No modulo operator.
- Arithmetic:
  - wet_scaled = (wet * gain) arithmetic-shifted right by GAIN_W, i.e. floor.
  - sum = dry + wet_scaled at DATA_W+1 bits; overflow handling depends on SAT_EN (see Optional Feature).
- Strobe while busy: ignored and sets overrun=1. The sequence in progress is unaffected.
- wr_ptr >= DEPTH is illegal input; behaviour is undefined, and the bench asserts it never happens.
- out_sample holds its value between out_valid pulses.

Optional Feature:
- Macro: ECHO_TAP_SAT_EN.
- Defined: the DATA_W+1-bit sum is saturated to [-32768, 32767].
- Undefined: the sum is truncated to DATA_W bits (two's-complement wrap), which saves the compare logic.

Decomposition:
- Package echo_pkg holds:
  - DEPTH, SAMPLES_PER_MS, DATA_W, ADDR_W, GAIN_W constants
  - a state enum typedef (IDLE, RD_DRY, RD_WET, CAPTURE, MIX, DONE)
  - sample_t (signed DATA_W) and addr_t typedefs
- Sub-module echo_mixer: registered multiply-shift-add-saturate stage, used for the MIX -> DONE path. The FSM, address arithmetic and overrun logic stay in the top module.

Test Plan:
- Reset: assert rst for 3 cycles -> all outputs 0, busy=0.
- Then strobe during rst -> no rd_en and no out_valid.
- Basic mix: wr_ptr=100, delay=0, gain=128, RAM[100]=1000, strobe at T -> rd_addr=100 at T+1 and T+2; out_valid at T+5 with out_sample=1500.
- Wrap: wr_ptr=10, delay=1 -> rd_addr at T+2 = 132266.
- Clamp: wr_ptr=5, delay=4095 (180180 samples) -> rd_addr at T+2 = 6.
- Saturation: dry=30000, wet=30000, gain=255 -> wet_scaled=29882.
  - With ECHO_TAP_SAT_EN: out_sample=32767.
  - Without ECHO_TAP_SAT_EN: out_sample=-5654.
- Negative saturation (SAT_EN): dry=-30000, wet=-30000, gain=255 -> out_sample=-32768.
- Overrun: strobes at T and T+2 -> one out_valid at T+5 only; overrun=1 from T+3 and stays set until rst.
- Strobe at T+6 is accepted normally.
